pwm_capture: RTL and testbench

Measures an incoming PWM waveform and reports its period and high time in `clk` cycles. It is the receive end of the PWM path: it sits on a pin or loopback net driven by a PWM timer/counter, and it feeds the sensor/feedback logic of the elevator controller. It also flags a stuck-high or stuck-low input.

---
 rtl/pwm_capture_if.sv | 32 +++
 rtl/pwm_capture.sv | 174 +++++++++++++++++
 tb/tb_pwm_capture.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - control and result signals of the PWM capture block
//
// Ports (signals):
//   enable      - measurement enable, driven by the master
//   pwm_in      - raw asynchronous PWM input, driven by the master
//   period      - cycles between the last two rising edges
//   high_time   - cycles high within that period
//   valid       - one-cycle pulse when period/high_time update
//   stuck       - one-cycle pulse when the input timeout fires
//   stuck_level - synchronized input level captured at the last timeout
// Modports: master (stimulus/consumer side), slave (pwm_capture side).
interface pwm_capture_if #(
  parameter int WIDTH = 16
);
  logic             enable;
  logic             pwm_in;
  logic [WIDTH-1:0] period;
  logic [WIDTH-1:0] high_time;
  logic             valid;
  logic             stuck;
  logic             stuck_level;

  modport master (
    output enable, pwm_in,
    input  period, high_time, valid, stuck, stuck_level
  );

  modport slave (
    input  enable, pwm_in,
    output period, high_time, valid, stuck, stuck_level
  );
endinterface

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - measures PWM period and high time, flags a stuck input
//
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset
//   bus    - pwm_capture_if.slave: enable/pwm_in in; period, high_time,
//            valid, stuck, stuck_level out
// Optional feature: define PWM_CAPTURE_FILTER_EN to insert a 3-sample
// stability filter after the synchronizer (edge latency 5 instead of 3).
module pwm_capture #(
  parameter int WIDTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  pwm_capture_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HIGH, LOW} state_t;

  state_t           state, state_nxt;
  logic             sync1, sync2;
  logic             prev;
  logic             lvl;
  logic             rise, fall, sat;
  logic [WIDTH-1:0] pcnt, hcnt, pcnt_nxt, hcnt_nxt;
  logic [WIDTH-1:0] pcnt_inc;
  logic             load, timeout;

  logic [WIDTH-1:0] period_r, high_time_r;
  logic             valid_r, stuck_r, stuck_level_r;

  // Two-flop synchronizer for the asynchronous input.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.pwm_in;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_FILTER_EN
  // The filtered level only moves once three consecutive synchronized
  // samples agree; otherwise it holds the previous filtered level (prev).
  logic [1:0] hist;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist <= 2'b00;
    end else begin
      hist <= {hist[0], sync2};
    end
  end

  assign lvl = ((sync2 == hist[0]) && (hist[0] == hist[1])) ? sync2 : prev;
`else
  assign lvl = sync2;
`endif

  // Edge-detect register; prev resets low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev <= 1'b0;
    end else begin
      prev <= lvl;
    end
  end

  assign rise = lvl & ~prev;
  assign fall = ~lvl & prev;
  assign sat  = (pcnt == {WIDTH{1'b1}});
  // An edge in the saturation cycle wins over the timeout; holding at the
  // maximum keeps the counter from wrapping in that case.
  assign pcnt_inc = sat ? pcnt : pcnt + WIDTH'(1);

  always_comb begin
    state_nxt = state;
    pcnt_nxt  = pcnt;
    hcnt_nxt  = hcnt;
    load      = 1'b0;
    timeout   = 1'b0;
    if (!bus.enable) begin
      state_nxt = IDLE;
      pcnt_nxt  = '0;
      hcnt_nxt  = '0;
    end else begin
      case (state)
        IDLE: begin
          pcnt_nxt = '0;
          hcnt_nxt = '0;
          if (rise) begin
            pcnt_nxt  = WIDTH'(1);
            hcnt_nxt  = WIDTH'(1);
            state_nxt = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            pcnt_nxt  = pcnt_inc;
            state_nxt = LOW;
          end else if (sat) begin
            timeout = 1'b1;
          end else begin
            pcnt_nxt = pcnt + WIDTH'(1);
            hcnt_nxt = hcnt + WIDTH'(1);
          end
        end
        LOW: begin
          if (rise) begin
            load      = 1'b1;
            pcnt_nxt  = WIDTH'(1);
            hcnt_nxt  = WIDTH'(1);
            state_nxt = HIGH;
          end else if (sat) begin
            timeout = 1'b1;
          end else begin
            pcnt_nxt = pcnt + WIDTH'(1);
          end
        end
        default: begin
          state_nxt = IDLE;
          pcnt_nxt  = '0;
          hcnt_nxt  = '0;
        end
      endcase
      if (timeout) begin
        state_nxt = IDLE;
        pcnt_nxt  = '0;
        hcnt_nxt  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      pcnt  <= '0;
      hcnt  <= '0;
    end else begin
      state <= state_nxt;
      pcnt  <= pcnt_nxt;
      hcnt  <= hcnt_nxt;
    end
  end

  // Results are registered together with their pulses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      period_r      <= '0;
      high_time_r   <= '0;
      valid_r       <= 1'b0;
      stuck_r       <= 1'b0;
      stuck_level_r <= 1'b0;
    end else begin
      valid_r <= load;
      stuck_r <= timeout;
      if (load) begin
        period_r    <= pcnt;
        high_time_r <= hcnt;
      end
      if (timeout) begin
        stuck_level_r <= lvl;
      end
    end
  end

  assign bus.period      = period_r;
  assign bus.high_time   = high_time_r;
  assign bus.valid       = valid_r;
  assign bus.stuck       = stuck_r;
  assign bus.stuck_level = stuck_level_r;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  typedef struct {
    int p;
    int h;
  } meas_t;

  logic clk = 1'b0;
  logic reset;
  logic pwm;
  logic en;

  always #5 clk = ~clk;

  pwm_capture_if #(.WIDTH(16)) ifa ();
  pwm_capture_if #(.WIDTH(8))  ifb ();

  assign ifa.enable = en;
  assign ifa.pwm_in = pwm;
  assign ifb.enable = en;
  assign ifb.pwm_in = pwm;

  pwm_capture #(.WIDTH(16)) dut_a (.clk(clk), .reset(reset), .bus(ifa));
  pwm_capture #(.WIDTH(8))  dut_b (.clk(clk), .reset(reset), .bus(ifb));

  meas_t exp_q[$];
  int    n_checks = 0;
  int    n_fail   = 0;
  int    cyc      = 0;
  int    b_valids = 0;
  logic  a_prev_valid = 1'b0;

  // Measurement model: a period is the distance between two driven rises,
  // the high time the distance from a rise to the following fall.
  bit    armed = 1'b0;
  int    last_rise = 0;
  int    last_fall = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic set_pwm(input logic v);
    if (v && !pwm) begin
      if (armed) exp_q.push_back('{p: cyc - last_rise, h: last_fall - last_rise});
      armed     = 1'b1;
      last_rise = cyc;
    end else if (!v && pwm) begin
      last_fall = cyc;
    end
    pwm = v;
  endtask

  task automatic set_en(input logic v);
    en = v;
    if (!v) armed = 1'b0;
  endtask

  task automatic pwm_cycle(input int per, input int hi);
    set_pwm(1'b1);
    wait_cycles(hi);
    set_pwm(1'b0);
    wait_cycles(per - hi);
  endtask

  // Scoreboard consumer for the WIDTH=16 instance.
  always @(negedge clk) begin
    if (reset === 1'b1) begin
      if (ifa.valid) begin : pop_blk
        meas_t m;
        check("a_valid_width", {31'd0, a_prev_valid}, 0);
        if (exp_q.size() == 0) begin
          check("a_unexpected_valid", {31'd0, ifa.valid}, 0);
        end else begin
          m = exp_q.pop_front();
          check("a_period", {16'd0, ifa.period}, m.p);
          check("a_high_time", {16'd0, ifa.high_time}, m.h);
        end
      end
      if (ifb.valid) b_valids <= b_valids + 1;
      if (ifb.stuck) check("b_valid_stuck_exclusive", {31'd0, ifb.valid}, 0);
    end
    a_prev_valid <= ifa.valid;
  end

  initial begin : stim
    int found;
    int bv;
    reset = 1'b0;
    en    = 1'b0;
    pwm   = 1'b0;
    wait_cycles(3);
    check("rst_a_period", {16'd0, ifa.period}, 0);
    check("rst_a_high_time", {16'd0, ifa.high_time}, 0);
    check("rst_a_valid", {31'd0, ifa.valid}, 0);
    check("rst_a_stuck", {31'd0, ifa.stuck}, 0);
    check("rst_a_stuck_level", {31'd0, ifa.stuck_level}, 0);
    check("rst_b_period", {24'd0, ifb.period}, 0);
    reset = 1'b1;
    wait_cycles(2);
    set_en(1'b1);

    // Steady 1000/250 stream, then a duty change to 750.
    pwm_cycle(1000, 250);
    pwm_cycle(1000, 250);
    pwm_cycle(1000, 250);
    pwm_cycle(1000, 750);
    pwm_cycle(1000, 750);

    // Enable dropped for 10 cycles inside the low phase.
    set_pwm(1'b1);
    wait_cycles(250);
    set_pwm(1'b0);
    wait_cycles(300);
    set_en(1'b0);
    wait_cycles(10);
    set_en(1'b1);
    wait_cycles(440);
    set_pwm(1'b1);
    wait_cycles(20);
    check("hold_period_after_disable", {16'd0, ifa.period}, 1000);
    check("hold_high_after_disable", {16'd0, ifa.high_time}, 750);
    wait_cycles(230);
    set_pwm(1'b0);
    wait_cycles(750);

    // 2-cycle glitch inside the low phase.
    set_pwm(1'b1);
    wait_cycles(250);
    set_pwm(1'b0);
    wait_cycles(400);
`ifdef PWM_CAPTURE_FILTER_EN
    pwm = 1'b1;
    wait_cycles(2);
    pwm = 1'b0;
`else
    set_pwm(1'b1);
    wait_cycles(2);
    set_pwm(1'b0);
`endif
    wait_cycles(348);

    // Reset asserted during the high phase.
    set_pwm(1'b1);
    wait_cycles(50);
    check("queue_drained_before_reset", exp_q.size(), 0);
    reset = 1'b0;
    #1;
    check("midrst_a_period", {16'd0, ifa.period}, 0);
    check("midrst_a_high_time", {16'd0, ifa.high_time}, 0);
    check("midrst_a_valid", {31'd0, ifa.valid}, 0);
    armed = 1'b0;
    set_pwm(1'b0);
    wait_cycles(3);
    reset = 1'b1;
    wait_cycles(2);
    pwm_cycle(1000, 250);

    // Stuck high on the WIDTH=8 instance: counter reaches 255 254 cycles
    // after the rise is acted on, the registered pulse follows one edge
    // later, and the rise itself is acted on 3 edges after pwm_in changes.
    bv = b_valids;
    set_pwm(1'b1);
    found = 0;
    for (int i = 1; i <= 400; i++) begin
      wait_cycles(1);
      if (ifb.stuck) begin
        found = i;
        break;
      end
    end
    check("b_stuck_high_latency", found, 258);
    check("b_stuck_level_high", {31'd0, ifb.stuck_level}, 1);
    wait_cycles(1);
    check("b_stuck_width", {31'd0, ifb.stuck}, 0);

    // Stuck low: one 20-cycle high pulse, then held low.
    set_pwm(1'b0);
    wait_cycles(10);
    set_pwm(1'b1);
    found = 0;
    for (int i = 1; i <= 400; i++) begin
      wait_cycles(1);
      if (ifb.stuck) begin
        found = i;
        break;
      end
      if (i == 20) set_pwm(1'b0);
    end
    check("b_stuck_low_latency", found, 258);
    check("b_stuck_level_low", {31'd0, ifb.stuck_level}, 0);
    check("b_no_valid_when_stuck", b_valids, bv);

    set_pwm(1'b1);
    wait_cycles(10);
    check("queue_drained_at_end", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
